// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the instruction fetch stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo : DEPTH-entry FIFO of fetch_entry_t with synchronous clear
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           push,
    input  fetch_entry_t                   push_data,
    input  logic                           pop,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output fetch_entry_t                   head
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t       r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != c_CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !clear && (r_count == c_CNT_W'(DEPTH)) && !w_pop));

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit : credit-limited in-order fetch stage with response buffer
// Option macro: FETCH_ALIGN_CHECK_EN (block misaligned fetches, raise FetchFault)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit #(
    parameter int              XLEN        = 32,
    parameter int              BUF_DEPTH   = 2,
    parameter logic [XLEN-1:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            Reset_n,
    input  logic [XLEN-1:0] PC,
    output logic            PCAdvance,
    input  logic            Flush,
    output logic            ImemReqValid,
    output logic [XLEN-1:0] ImemReqAddr,
    input  logic            ImemReqReady,
    input  logic            ImemRspValid,
    input  logic [XLEN-1:0] ImemRspData,
    output logic            InstrValid,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] InstrPC,
    input  logic            InstrReady,
    output logic            FetchFault
);

    import fetch_pkg::*;

    localparam int              c_CNT_W      = $clog2(BUF_DEPTH + 1);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_drop;
    logic [c_CNT_W-1:0] w_outstanding_next;
    logic [c_CNT_W-1:0] w_drop_next;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic [c_CNT_W-1:0] w_aq_count;
    fetch_entry_t       w_fifo_head;
    fetch_entry_t       w_aq_head;
    fetch_entry_t       w_rsp_entry;
    fetch_entry_t       w_aq_entry;
    logic               w_credit;
    logic               w_pc_ok;
    logic               w_accept;
    logic               w_rsp_any;
    logic               w_rsp_keep;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_fault;

    assign ImemReqAddr = PC & c_ALIGN_MASK;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    assign w_pc_ok = (PC[1:0] == 2'b00);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)                          r_fault <= 1'b0;
        else if (Flush)                        r_fault <= 1'b0;
        else if (r_state == S_RUN && !w_pc_ok) r_fault <= 1'b1;
    end

    assign w_fault = r_fault;
`else
    assign w_pc_ok = 1'b1;
    assign w_fault = 1'b0;
`endif

    assign FetchFault = w_fault;

    // Buffered plus in-flight never exceeds BUF_DEPTH, so responses always fit.
    assign w_credit = ({1'b0, r_outstanding} + {1'b0, w_fifo_count})
                      < (c_CNT_W + 1)'(BUF_DEPTH);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_RUN;
            S_RUN:   if (Flush && (r_outstanding != '0)) w_state_next = S_DRAIN;
            S_DRAIN: if (w_drop_next == '0)              w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ImemReqValid = (r_state == S_RUN) && !Flush && w_credit && w_pc_ok;
        PCAdvance    = ImemReqValid && ImemReqReady;
    end

    assign w_accept   = ImemReqValid && ImemReqReady;
    assign w_rsp_any  = ImemRspValid && (r_state != S_IDLE);
    assign w_rsp_keep = ImemRspValid && (r_state == S_RUN) && !Flush;

    // A response arriving in the flush cycle is itself dropped, so it is not counted in drop.
    always_comb begin
        w_outstanding_next = r_outstanding + c_CNT_W'(w_accept) - c_CNT_W'(w_rsp_any);
        w_drop_next        = r_drop;
        if (r_state == S_RUN && Flush)
            w_drop_next = r_outstanding - c_CNT_W'(ImemRspValid);
        else if (r_state == S_DRAIN && w_rsp_any)
            w_drop_next = r_drop - 1'b1;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            r_drop        <= w_drop_next;
        end
    end

    always_comb begin
        w_rsp_entry       = w_aq_head;
        w_rsp_entry.instr = ImemRspData;
    end

    assign w_aq_entry = '{addr: ImemReqAddr, instr: '0};

    fetch_fifo #(
        .DEPTH     (BUF_DEPTH)
    ) u_addr_q (
        .clk       (clk),
        .rst_n     (Reset_n),
        .clear     (Flush),
        .push      (w_accept),
        .push_data (w_aq_entry),
        .pop       (w_rsp_keep),
        .count     (w_aq_count),
        .head      (w_aq_head)
    );

    fetch_fifo #(
        .DEPTH     (BUF_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (Reset_n),
        .clear     (Flush),
        .push      (w_rsp_keep),
        .push_data (w_rsp_entry),
        .pop       (w_pop),
        .count     (w_fifo_count),
        .head      (w_fifo_head)
    );

    assign w_fifo_empty = (w_fifo_count == '0);
    assign InstrValid   = !w_fifo_empty && !Flush;
    assign w_pop        = InstrValid && InstrReady;
    assign Instr        = w_fifo_empty ? RESET_INSTR : w_fifo_head.instr;
    assign InstrPC      = w_fifo_empty ? '0 : w_fifo_head.addr;

    a_rsp_has_addr: assert property (@(posedge clk) disable iff (!Reset_n)
        !(w_rsp_keep && (w_aq_count == '0)));

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit : randomized scoreboard bench for instr_fetch_unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

    localparam int          c_DEPTH = 2;
    localparam logic [31:0] c_NOP   = 32'h0000_0013;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit c_ALIGN_EN = 1'b1;
`else
    localparam bit c_ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Reset_n;
    logic [31:0] PC;
    logic        PCAdvance;
    logic        Flush;
    logic        ImemReqValid;
    logic [31:0] ImemReqAddr;
    logic        ImemReqReady;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrReady;
    logic        FetchFault;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN         (32),
        .BUF_DEPTH    (c_DEPTH),
        .RESET_INSTR  (c_NOP)
    ) dut (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .PC           (PC),
        .PCAdvance    (PCAdvance),
        .Flush        (Flush),
        .ImemReqValid (ImemReqValid),
        .ImemReqAddr  (ImemReqAddr),
        .ImemReqReady (ImemReqReady),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrReady   (InstrReady),
        .FetchFault   (FetchFault)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q[$];
    logic [31:0] mq_addr[$];
    int          mq_rdy[$];
    int          cyc = 0;
    bit          started;
    bit          draining;
    bit          fault_m;
    int          buf_cnt;
    int          drop_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        mq_addr.delete();
        mq_rdy.delete();
        started  = 1'b0;
        draining = 1'b0;
        fault_m  = 1'b0;
        buf_cnt  = 0;
        drop_m   = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid",   ImemReqValid, 0);
        check("rst_pc_advance",  PCAdvance,    0);
        check("rst_instr_valid", InstrValid,   0);
        check("rst_instr",       Instr,        c_NOP);
        check("rst_instr_pc",    InstrPC,      0);
        check("rst_fetch_fault", FetchFault,   0);
    endtask

    task automatic drive_inputs();
        logic [31:0] pc_v;
        pc_v = 32'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 9) == 0) pc_v[1:0] = 2'($urandom_range(1, 3));
        PC           = pc_v;
        ImemReqReady = ($urandom_range(0, 3) != 0);
        InstrReady   = ($urandom_range(0, 2) != 0);
        Flush        = ($urandom_range(0, 29) == 0);
        if (mq_addr.size() > 0 && mq_rdy[0] <= cyc && $urandom_range(0, 3) != 0) begin
            ImemRspValid = 1'b1;
            ImemRspData  = memfn(mq_addr[0]);
        end else begin
            ImemRspValid = 1'b0;
            ImemRspData  = $urandom;
        end
    endtask

    // One cycle: drive at negedge, check and advance the reference model before posedge.
    task automatic step();
        bit          exp_req;
        bit          acc;
        bit          rsp;
        bit          pop;
        bit          run;
        bit          was_drain;
        logic [31:0] a;
        @(negedge clk);
        drive_inputs();
        #2;
        run     = started && !draining;
        exp_req = run && !Flush && (mq_addr.size() + buf_cnt < c_DEPTH)
                  && (!c_ALIGN_EN || PC[1:0] == 2'b00);
        check("req_valid",   ImemReqValid, exp_req);
        check("pc_advance",  PCAdvance,    exp_req && ImemReqReady);
        if (exp_req) check("req_addr", ImemReqAddr, PC & 32'hFFFF_FFFC);
        check("instr_valid", InstrValid,   (buf_cnt > 0) && !Flush);
        check("fetch_fault", FetchFault,   fault_m);
        if (buf_cnt == 0) begin
            check("empty_instr", Instr,   c_NOP);
            check("empty_pc",    InstrPC, 0);
        end

        acc       = exp_req && ImemReqReady;
        rsp       = ImemRspValid;
        pop       = (buf_cnt > 0) && !Flush && InstrReady;
        was_drain = draining;
        if (Flush) begin
            if (run && mq_addr.size() > 0) begin
                draining = 1'b1;
                drop_m   = mq_addr.size() - int'(rsp);
            end else if (draining && rsp) begin
                drop_m--;
            end
            buf_cnt = 0;
            exp_q.delete();
        end else begin
            if (rsp && draining)     drop_m--;
            else if (rsp && started) buf_cnt++;
            if (pop) buf_cnt--;
        end
        if (rsp) begin
            void'(mq_addr.pop_front());
            void'(mq_rdy.pop_front());
        end
        if (acc) begin
            a = PC & 32'hFFFF_FFFC;
            mq_addr.push_back(a);
            mq_rdy.push_back(cyc + 1 + int'($urandom_range(0, 3)));
            exp_q.push_back('{addr: a, instr: memfn(a)});
        end
        if (was_drain && drop_m == 0) draining = 1'b0;
        if (c_ALIGN_EN) fault_m = Flush ? 1'b0 : (fault_m || (run && PC[1:0] != 2'b00));
        started = 1'b1;
        cyc++;
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs();
        ImemRspValid = 1'b0;
        Flush        = 1'b0;
        clear_model();
        repeat (hold) @(posedge clk);
        #1;
        Reset_n = 1'b1;
    endtask

    // Decode-side monitor: every entry consumed by decode must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (Reset_n === 1'b1 && InstrValid === 1'b1 && InstrReady === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL decode_pop: got pc %h instr %h expected no entry", InstrPC, Instr);
                end else begin
                    e = exp_q.pop_front();
                    check("decode_pc",    InstrPC, e.addr);
                    check("decode_instr", Instr,   e.instr);
                end
            end
        end
    end

    initial begin
        Reset_n      = 1'b0;
        PC           = '0;
        Flush        = 1'b0;
        ImemReqReady = 1'b0;
        ImemRspValid = 1'b0;
        ImemRspData  = '0;
        InstrReady   = 1'b0;
        clear_model();
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        Reset_n = 1'b1;

        repeat (2000) step();
        do_reset(3);
        repeat (2000) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
